mmm_sequencer: RTL and testbench
================================

MMM_SEQUENCER -- requirements
Module: mmm_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand width in bits and the number of iteration cycles; legal values are WIDTH >= 2.
REQ-002 clk  input  1  Rising-edge clock.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 ena  input  1  Global clock enable; 0 freezes the sequencer.
REQ-005 start  input  1  Operation request; sampled only in IDLE.
REQ-006 abort  input  1  Synchronous cancel of an operation in flight.
REQ-007 r_ge_n  input  1  Datapath comparator flag: R >= N.
REQ-008 clear  output  1  Active-low clear strobe to the R register.
REQ-009 ld_r  output  1  Load enable to the R register.
REQ-010 lock  output  1  Load-source select: 1 = subtracted value (R-N); 0 = accumulator sum.
REQ-011 bit_idx  output  $clog2(WIDTH)  Current operand-bit index.
REQ-012 busy  output  1  High in every state except IDLE.
REQ-013 done  output  1  One-cycle completion pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, ITER, COMPARE, SUB and DONE; the state register and bit_idx SHALL be flops, and all other outputs SHALL be a Moore decode of the state, qualified by ena.
REQ-015 IDLE SHALL move to CLEAR when ena=1 and start=1; otherwise IDLE SHALL hold.
REQ-016 CLEAR SHALL drive clear=0 for one cycle and then enter ITER with bit_idx=0.
REQ-017 ITER SHALL drive ld_r=1 and lock=0, and SHALL increment bit_idx by 1 each enabled cycle.
REQ-018 ITER SHALL last exactly WIDTH enabled cycles; at bit_idx=WIDTH-1 the next state SHALL be COMPARE and bit_idx SHALL wrap to 0.
REQ-019 COMPARE SHALL drive no strobes for one cycle.
REQ-020 In COMPARE, r_ge_n=1 SHALL select SUB as the next state, and r_ge_n=0 SHALL select DONE.
REQ-021 SUB SHALL drive ld_r=1 and lock=1 for one cycle, then enter DONE.
REQ-022 DONE SHALL drive done=1 for one cycle, then return to IDLE.
REQ-023 Default (inactive) output levels SHALL be clear=1, ld_r=0, lock=0 and done=0.
REQ-024 With ena=0, the state and bit_idx SHALL hold and the outputs SHALL be forced to their defaults; busy SHALL keep reflecting the held state.
REQ-025 When ena returns to 1, the sequence SHALL resume exactly where it stopped, with no cycle lost or repeated.
REQ-026 Latency, counted in enabled cycles from the IDLE cycle that samples start: done SHALL appear at cycle WIDTH+3 without subtraction, and at cycle WIDTH+4 with subtraction.
REQ-027 start SHALL be ignored while busy=1, and no request SHALL be queued.
REQ-028 When ena=1 and abort=1 in any non-IDLE state, the next state SHALL be IDLE with bit_idx=0 and no done pulse.
REQ-029 abort SHALL take priority over every other transition, including the DONE to IDLE transition.
REQ-030 abort asserted in IDLE SHALL have no effect; abort and start asserted together in IDLE SHALL start the operation.
REQ-031 A start held high continuously SHALL begin a new operation in the IDLE cycle that follows DONE.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, bit_idx=0, clear=1, ld_r=0, lock=0, busy=0 and done=0, regardless of clk and ena.
REQ-033 rst asserted mid-operation SHALL discard the operation with no done pulse.
REQ-034 After rst deasserts, the block SHALL accept start on the first following rising clk edge.

Verification
REQ-035 WIDTH=4, ena=1, start pulsed, r_ge_n=0 -> clear=0 on cycle 1; ld_r=1 with lock=0 on cycles 2-5 with bit_idx 0,1,2,3; done=1 on cycle 7; busy=1 on cycles 1-7.
REQ-036 Same stimulus as REQ-035 with r_ge_n=1 in COMPARE -> ld_r=1 with lock=1 on cycle 7; done=1 on cycle 8.
REQ-037 ena=0 for 3 cycles while bit_idx=1 in ITER -> ld_r=0 and bit_idx=1 held for those cycles; done is delayed by exactly 3 cycles.
REQ-038 abort=1 while bit_idx=2 in ITER -> IDLE on the next cycle, busy=0, no done pulse; a fresh start then completes normally.
REQ-039 start re-pulsed during ITER -> no effect on the sequence; exactly one done pulse.
REQ-040 rst pulsed asynchronously in SUB -> all outputs at reset values before the next clk edge; no done pulse.

Source files
------------

// File: rtl/mmm_sequencer.sv
// Control sequencer for a bit-serial Montgomery multiplier: clears R, iterates
// WIDTH accumulate cycles, then conditionally subtracts N before signalling done.
module mmm_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     r_ge_n,
    output logic                     clear,
    output logic                     ld_r,
    output logic                     lock,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ITER    = 3'd2,
        COMPARE = 3'd3,
        SUB     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state_r;

    // State and bit-index register; everything holds while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            bit_idx <= '0;
        end else if (ena) begin
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                bit_idx <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            state_r <= CLEAR;
                        end
                        bit_idx <= '0;
                    end
                    CLEAR: begin
                        state_r <= ITER;
                        bit_idx <= '0;
                    end
                    ITER: begin
                        if (bit_idx == LAST_IDX) begin
                            state_r <= COMPARE;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                    COMPARE: begin
                        state_r <= r_ge_n ? SUB : DONE;
                        bit_idx <= '0;
                    end
                    SUB: begin
                        state_r <= DONE;
                        bit_idx <= '0;
                    end
                    DONE: begin
                        state_r <= IDLE;
                        bit_idx <= '0;
                    end
                    default: begin
                        state_r <= IDLE;
                        bit_idx <= '0;
                    end
                endcase
            end
        end else begin
            state_r <= state_r;
            bit_idx <= bit_idx;
        end
    end

    // Moore strobe decode, gated by ena so a frozen sequencer drives idle levels.
    always_comb begin
        clear = 1'b1;
        ld_r  = 1'b0;
        lock  = 1'b0;
        done  = 1'b0;
        busy  = (state_r != IDLE);
        if (ena) begin
            case (state_r)
                CLEAR: clear = 1'b0;
                ITER:  ld_r  = 1'b1;
                SUB: begin
                    ld_r = 1'b1;
                    lock = 1'b1;
                end
                DONE:    done = 1'b1;
                default: clear = 1'b1;
            endcase
        end else begin
            clear = 1'b1;
        end
    end

endmodule

// File: tb/tb_mmm_sequencer.sv
// Randomized scoreboard bench: a per-operation token schedule predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_mmm_sequencer;

    localparam int WIDTH = 4;
    localparam int IW = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic r_ge_n = 1'b0;
    logic clear, ld_r, lock, busy, done;
    logic [IW-1:0] bit_idx;

    mmm_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
        .r_ge_n(r_ge_n), .clear(clear), .ld_r(ld_r), .lock(lock),
        .bit_idx(bit_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          clr_n;
        logic          ld;
        logic          lk;
        logic          dn;
        logic          is_cmp;
        logic [IW-1:0] idx;
    } tok_t;

    typedef struct packed {
        logic          clear;
        logic          ld_r;
        logic          lock;
        logic          done;
        logic          busy;
        logic [IW-1:0] idx;
    } exp_t;

    tok_t sched[$];
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int exp_dones = 0;
    int seen_dones = 0;

    function automatic tok_t mk(logic c, logic l, logic k, logic d, logic m, int i);
        tok_t t;
        t.clr_n = c; t.ld = l; t.lk = k; t.dn = d; t.is_cmp = m; t.idx = IW'(i);
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts this cycle's outputs and the next state.
    task automatic step(input logic e, input logic s, input logic a, input logic g, input bit do_rst);
        tok_t t;
        exp_t x;
        @(posedge clk);
        #1;
        ena = e; start = s; abort = a; r_ge_n = g;
        if (do_rst) begin
            rst = 1'b1;
            sched.delete();
            #1;
            chk("rst_clear", int'(clear), 1);
            chk("rst_ld_r", int'(ld_r), 0);
            chk("rst_lock", int'(lock), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_bit_idx", int'(bit_idx), 0);
        end
        t = (sched.size() != 0) ? sched[0] : mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        x.clear = e ? t.clr_n : 1'b1;
        x.ld_r  = e & t.ld;
        x.lock  = e & t.lk;
        x.done  = e & t.dn;
        x.busy  = (sched.size() != 0);
        x.idx   = t.idx;
        if (x.done) exp_dones++;
        exp_q.push_back(x);
        if (e) begin
            if (sched.size() != 0) begin
                if (a) begin
                    sched.delete();
                end else begin
                    t = sched.pop_front();
                    if (t.is_cmp && g) sched.push_front(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
                end
            end else if (s) begin
                sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
                for (int i = 0; i < WIDTH; i++) sched.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i));
                sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0));
                sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
            end
        end
        if (do_rst) begin
            @(negedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic run(input int n, input logic g);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, g, 1'b0);
    endtask

    // Monitor: every negedge compare the DUT against the oldest prediction.
    always @(negedge clk) begin
        exp_t x;
        if (done) seen_dones++;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("clear", int'(clear), int'(x.clear));
            chk("ld_r", int'(ld_r), int'(x.ld_r));
            chk("lock", int'(lock), int'(x.lock));
            chk("done", int'(done), int'(x.done));
            chk("busy", int'(busy), int'(x.busy));
            chk("bit_idx", int'(bit_idx), int'(x.idx));
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Plain operation, then one that needs the final subtraction.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(10, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); run(10, 1'b1);
        // Freeze for three cycles at bit_idx=1.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(10, 1'b0);
        // Abort at bit_idx=2, then a fresh operation.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); run(3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(10, 1'b0);
        // Re-pulsed start during ITER is ignored.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(10, 1'b0);
        // Start held high back-to-back, and abort+start together in IDLE.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'(i % 2), 1'b0);
        run(10, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); run(10, 1'b0);
        // Abort in DONE.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); run(6, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); run(3, 1'b0);
        // Asynchronous reset while in SUB.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); run(6, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); run(10, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) == 0);
        end
        run(12, 1'b0);
        @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        chk("done_count", seen_dones, exp_dones);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
